sar_request_arbiter: RTL
========================

// Module: sar_request_arbiter
// PURPOSE
//  Shares one SARFastVerilog engine between NREQ requesters. Requesters post Inc/Dcr
//  search requests with a data word; the block grants one at a time (round-robin), drives
//  the engine's Inc/Dcr/DataOut and watches its StateP. It captures SAROut when the engine
//  returns to idle and hands the result back tagged with the requester index.
// PARAMETERS
//  DATA     8   data/SAR word width; must match the engine's DATA
//  NREQ     4   number of requesters (2..16)
//  IDW      2   requester index width, >= clog2(NREQ)
//  TMO      64  engine-busy timeout in clocks; 0 disables the timeout
// PORTS
//  Clock      in   1          system clock, rising edge
//  Reset      in   1          asynchronous, active-high reset
//  ReqInc     in   NREQ       per-requester increment-search request (level)
//  ReqDcr     in   NREQ       per-requester decrement-search request (level)
//  ReqData    in   NREQ*DATA  per-requester data word; slice i = [i*DATA +: DATA]
//  Grant      out  NREQ       one-hot grant; requester holds Req*/ReqData while granted
//  SarInc     out  1          to engine Inc
//  SarDcr     out  1          to engine Dcr
//  SarData    out  DATA       to engine DataOut = granted requester's ReqData
//  SarStateP  in   2          from engine StateP
//  SarOut     in   DATA       from engine SAROut
//  Done       out  1          one-cycle pulse: Result/ResultId valid
//  Result     out  DATA       captured SarOut; held until the next Done
//  ResultId   out  IDW        index of the requester that owns Result
//  TimedOut   out  1          sticky; set on engine timeout, cleared only by Reset
// BEHAVIOUR
//  Reset: FSM=WAIT_IDLE; Grant=0, SarInc=0, SarDcr=0, SarData=0, Done=0, Result=0,
//   ResultId=0, TimedOut=0; round-robin pointer=0 (requester 0 has highest priority).
//  FSM states: WAIT_IDLE, ARB, ISSUE, BUSY, CAPTURE.
//   WAIT_IDLE: stay until SarStateP==00, then go to ARB. This covers the engine's own
//    reset state 11.
//   ARB: active_i = ReqInc[i]|ReqDcr[i]. With none active, stay. Otherwise pick the first
//    active index at or after the pointer (wrapping), register Grant and the index, go ISSUE.
//   ISSUE (exactly 1 cycle): SarInc=ReqInc[g]; SarDcr=ReqDcr[g]&~ReqInc[g]. Inc wins if
//    both are set. Go BUSY.
//   BUSY: wait until SarStateP!=00 has been seen at least once, and SarStateP is now 00.
//    Then go CAPTURE.
//   CAPTURE: Result<=SarOut; ResultId<=g; Done=1 for this cycle; Grant<=0;
//    pointer<=g+1 (wraps to 0 after NREQ-1). Go ARB.
//  SarData = ReqData slice of the granted index from ARB exit through CAPTURE; 0 otherwise.
//   It is registered, so it is stable while the engine samples it.
//  Latency: ARB->Done = 1 (ISSUE) + engine busy cycles + 1 (CAPTURE). No back-to-back issue:
//   at least one ARB cycle lies between grants.
//  Timeout (TMO>0): BUSY counter starts at 0 on entry. If it reaches TMO:
//   - TimedOut<=1;
//   - Done pulses with Result=0 and ResultId=g;
//   - grant is released and FSM goes to WAIT_IDLE.
//  Requester drops its request while granted: ignored; the operation completes and Done
//   still pulses.
//  Requester with ReqInc or ReqDcr still high after its Done: re-eligible in the next ARB,
//   at the lowest rotated priority.
//  Reset asserted mid-operation: everything returns to reset values at once; no Done. The
//   engine shares Reset and returns to 11, then 00.
//  Outputs Grant, SarInc, SarDcr, SarData, Done, Result, ResultId, TimedOut are all
//   registered.
// TESTING
//  1 Reset release with the engine model at 11 for 1 cycle, ReqInc=0001, ReqData0=8'h2C ->
//    Grant=0001 only after StateP==00; SarInc pulses 1 cycle with SarData=8'h2C; Done with
//    ResultId=0 and Result = engine SarOut.
//  2 ReqInc=1111 held -> Done ResultIds in order 0,1,2,3,0. Grant is always one-hot and
//    never overlaps.
//  3 ReqInc[2]=ReqDcr[2]=1 -> SarInc=1, SarDcr=0. ReqDcr[1] alone -> SarDcr=1, SarInc=0.
//  4 Engine model stuck at StateP=01, TMO=64 -> Done 65 clocks after ISSUE with Result=0,
//    TimedOut=1 and staying 1; FSM waits in WAIT_IDLE until StateP=00.
//  5 Reset pulsed while in BUSY -> all outputs 0 next cycle, no Done. After the engine
//    returns to 00, pending requests are serviced starting from requester 0.
//  6 ReqDcr[3] is dropped during BUSY -> Done still pulses with ResultId=3. The next grant
//    goes to requester 0 if it is pending.

Source files
------------

// File: rtl/sar_request_arbiter.sv
// Round-robin front end that lets NREQ requesters share one SAR search engine.
// Grants one requester at a time, drives Inc/Dcr/DataOut, and returns the tagged result.
module sar_request_arbiter #(
  parameter int DATA = 8,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int TMO  = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_inc_i,
  input  logic [NREQ-1:0]      req_dcr_i,
  input  logic [NREQ*DATA-1:0] req_data_i,
  output logic [NREQ-1:0]      grant_o,
  output logic                 sar_inc_o,
  output logic                 sar_dcr_o,
  output logic [DATA-1:0]      sar_data_o,
  input  logic [1:0]           sar_state_p_i,
  input  logic [DATA-1:0]      sar_out_i,
  output logic                 done_o,
  output logic [DATA-1:0]      result_o,
  output logic [IDW-1:0]       result_id_o,
  output logic                 timed_out_o
);

  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0]  TMO_LAST = (TMO > 0) ? CW'(TMO - 1) : '0;
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);
  localparam logic [IDW:0]   NREQ_W   = (IDW + 1)'(NREQ);

  typedef enum logic [2:0] {WAIT_IDLE, ARB, ISSUE, BUSY, CAPTURE} state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  gidx_q;
  logic            seen_q;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] grant_q;
  logic            sar_inc_q;
  logic            sar_dcr_q;
  logic [DATA-1:0] sar_data_q;
  logic            done_q;
  logic [DATA-1:0] result_q;
  logic [IDW-1:0]  result_id_q;
  logic            timed_out_q;

  logic [NREQ-1:0] active;
  logic [NREQ-1:0] rot;
  logic            pick_valid;
  logic [IDW-1:0]  pick_off;
  logic [IDW:0]    pick_sum;
  logic [IDW-1:0]  pick_idx;
  logic [IDW-1:0]  gnext;
  logic            tmo_hit;

  assign active = req_inc_i | req_dcr_i;

  // rot[k] is the request k places after the pointer, so bit 0 has top priority.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [IDW:0] sum;
    assign sum     = {1'b0, ptr_q} + (IDW + 1)'(gi);
    assign rot[gi] = active[(sum >= NREQ_W) ? IDW'(sum - NREQ_W) : sum[IDW-1:0]];
  end

  always_comb begin
    pick_valid = 1'b0;
    pick_off   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pick_valid = 1'b1;
        pick_off   = IDW'(k);
      end
    end
  end

  assign pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
  assign pick_idx = (pick_sum >= NREQ_W) ? IDW'(pick_sum - NREQ_W) : pick_sum[IDW-1:0];
  assign gnext    = (gidx_q == LAST_IDX) ? '0 : gidx_q + IDW'(1);
  assign tmo_hit  = (TMO != 0) && (cnt_q == TMO_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= WAIT_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      seen_q      <= 1'b0;
      cnt_q       <= '0;
      grant_q     <= '0;
      sar_inc_q   <= 1'b0;
      sar_dcr_q   <= 1'b0;
      sar_data_q  <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_id_q <= '0;
      timed_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        WAIT_IDLE: begin
          if (sar_state_p_i == 2'b00) state_q <= ARB;
        end
        ARB: begin
          if (pick_valid) begin
            grant_q    <= NREQ'(1) << pick_idx;
            gidx_q     <= pick_idx;
            sar_data_q <= req_data_i[pick_idx*DATA +: DATA];
            sar_inc_q  <= req_inc_i[pick_idx];
            sar_dcr_q  <= req_dcr_i[pick_idx] & ~req_inc_i[pick_idx];
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          sar_inc_q <= 1'b0;
          sar_dcr_q <= 1'b0;
          seen_q    <= 1'b0;
          cnt_q     <= '0;
          state_q   <= BUSY;
        end
        BUSY: begin
          if (sar_state_p_i != 2'b00) seen_q <= 1'b1;
          cnt_q <= cnt_q + CW'(1);
          // A real completion in the same cycle as the timeout takes precedence.
          if (seen_q && sar_state_p_i == 2'b00) begin
            result_q    <= sar_out_i;
            result_id_q <= gidx_q;
            done_q      <= 1'b1;
            state_q     <= CAPTURE;
          end else if (tmo_hit) begin
            timed_out_q <= 1'b1;
            result_q    <= '0;
            result_id_q <= gidx_q;
            done_q      <= 1'b1;
            grant_q     <= '0;
            sar_data_q  <= '0;
            ptr_q       <= gnext;
            state_q     <= WAIT_IDLE;
          end
        end
        CAPTURE: begin
          grant_q    <= '0;
          sar_data_q <= '0;
          ptr_q      <= gnext;
          state_q    <= ARB;
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  assign grant_o     = grant_q;
  assign sar_inc_o   = sar_inc_q;
  assign sar_dcr_o   = sar_dcr_q;
  assign sar_data_o  = sar_data_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign result_id_o = result_id_q;
  assign timed_out_o = timed_out_q;

endmodule
